// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver
// Time-multiplexed seven-segment driver. Digit codes and decimal points are
// captured into a shadow register on `load`. A prescaler steps through the
// digits, and each digit is decoded (decimal or hex) with optional
// leading-zero blanking. Each slot starts with a dead time during which all
// anodes are off, to prevent ghosting. All outputs are registered, and pin
// polarity is applied in those output registers.
//
// Handshake: there is no valid/ready pair. `load` is a single-cycle strobe
// that is always accepted; the shadow register updates on that same edge.
module sseg_scan_driver #(
    parameter int NDIG           = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W         = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   digits,
    input  logic [NDIG-1:0]     dp_in,
    input  logic                load,
    input  logic                hex_en,
    input  logic                lz_blank,
    output logic [6:0]          sseg,
    output logic                dp,
    output logic [NDIG-1:0]     an,
    output logic [IDX_W-1:0]    scan_idx
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    // Pin-level "off" patterns at the configured polarity
    localparam logic [6:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic            DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NDIG-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [4*NDIG-1:0] shadow_dig_q, shadow_dig_d;
    logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        sseg_q, sseg_d;
    logic              dp_q, dp_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;

    logic [3:0]        cur_code;
    logic              cur_dp;
    logic              upper_nz;
    logic              blank;
    logic [6:0]        seg_raw;
    logic [6:0]        seg_lit;
    logic [NDIG-1:0]   an_lit;

    // Shadow capture, prescaler and digit index advance
    always_comb begin
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        if (load) begin
            shadow_dig_d = digits;
            shadow_dp_d  = dp_in;
        end
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(NDIG - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Select the current digit; blank it if it and every digit above it are zero
    always_comb begin
        cur_code = 4'd0;
        cur_dp   = 1'b0;
        upper_nz = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = shadow_dig_q[4*i +: 4];
                cur_dp   = shadow_dp_q[i];
            end
            if ((IDX_W'(i) >= idx_q) && (shadow_dig_q[4*i +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end
        blank = lz_blank && (idx_q != '0) && !upper_nz;
    end

    // Segment decode (bit6 = a ... bit0 = g); codes 10..15 go dark unless hex_en is set
    always_comb begin
        seg_raw = 7'b0000000;
        case (cur_code)
            4'd0:  seg_raw = 7'b1111110;
            4'd1:  seg_raw = 7'b0110000;
            4'd2:  seg_raw = 7'b1101101;
            4'd3:  seg_raw = 7'b1111001;
            4'd4:  seg_raw = 7'b0110011;
            4'd5:  seg_raw = 7'b1011011;
            4'd6:  seg_raw = 7'b1011111;
            4'd7:  seg_raw = 7'b1110000;
            4'd8:  seg_raw = 7'b1111111;
            4'd9:  seg_raw = 7'b1111011;
            4'd10: seg_raw = hex_en ? 7'b1110111 : 7'b0000000;
            4'd11: seg_raw = hex_en ? 7'b0011111 : 7'b0000000;
            4'd12: seg_raw = hex_en ? 7'b1001110 : 7'b0000000;
            4'd13: seg_raw = hex_en ? 7'b0111101 : 7'b0000000;
            4'd14: seg_raw = hex_en ? 7'b1001111 : 7'b0000000;
            4'd15: seg_raw = hex_en ? 7'b1000111 : 7'b0000000;
            default: seg_raw = 7'b0000000;
        endcase
    end

    // Anode selection with dead time, and polarity applied to the output register inputs
    always_comb begin
        an_lit = '0;
        if (!(cnt_q < CNT_W'(BLANK_CYC))) begin
            for (int i = 0; i < NDIG; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    an_lit[i] = 1'b1;
                end
            end
        end
        seg_lit    = blank ? 7'b0000000 : seg_raw;
        sseg_d     = seg_lit ^ {7{(SEG_ACTIVE_LOW != 0)}};
        dp_d       = (cur_dp && !blank) ^ (SEG_ACTIVE_LOW != 0);
        an_d       = an_lit ^ {NDIG{(AN_ACTIVE_LOW != 0)}};
        scan_idx_d = idx_q;
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            sseg_q       <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            scan_idx_q   <= '0;
        end else begin
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sseg_q       <= sseg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            scan_idx_q   <= scan_idx_d;
        end
    end

    assign sseg     = sseg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: NDIG=4, REFRESH_DIV=4, BLANK_CYC=1,
// active-low anodes, active-high segments. `s` counts the post-reset edges,
// so the state that the next edge registers is cnt = s%4 and idx = (s/4)%4.
module tb_sseg_scan_driver;

  localparam int NDIG = 4;
  localparam int RD   = 4;
  localparam int BC   = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        load;
  logic        hex_en;
  logic        lz_blank;
  logic [6:0]  sseg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  scan_idx;

  int n_cmp  = 0;
  int n_fail = 0;
  int s      = 0;

  logic [6:0] scan_tab [4] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};

  // clock / reset block
  always #5 clk = ~clk;

  sseg_scan_driver #(
    .NDIG(NDIG), .REFRESH_DIV(RD), .BLANK_CYC(BC),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .load(load),
    .hex_en(hex_en), .lz_blank(lz_blank), .sseg(sseg), .dp(dp), .an(an),
    .scan_idx(scan_idx)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    s++;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] sseg_e,
                         input logic dp_e, input logic [1:0] idx_e);
    chk({tag, ".an"}, {4'b0, an}, {4'b0, an_e});
    chk({tag, ".sseg"}, {1'b0, sseg}, {1'b0, sseg_e});
    chk({tag, ".dp"}, {7'b0, dp}, {7'b0, dp_e});
    chk({tag, ".scan_idx"}, {6'b0, scan_idx}, {6'b0, idx_e});
  endtask

  task automatic goto_state(input int d, input int c);
    int budget;
    budget = 0;
    while (!(((s % RD) == c) && (((s / RD) % NDIG) == d)) && (budget < 64)) begin
      tick();
      budget++;
    end
    if (budget >= 64) begin
      n_cmp++;
      n_fail++;
      $error("FAIL goto_state: observed timeout expected digit %0d cnt %0d", d, c);
    end
  endtask

  task automatic check_slot(input string tag, input int d, input logic [6:0] sseg_e, input logic dp_e);
    logic [3:0] an_e;
    goto_state(d, 1);
    tick();
    an_e = ~(4'b0001 << d);
    chk_out(tag, an_e, sseg_e, dp_e, 2'(d));
  endtask

  task automatic do_load(input logic [15:0] dg, input logic [3:0] dpv);
    digits = dg;
    dp_in  = dpv;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  // directed steps
  initial begin
    rst_n    = 1'b0;
    digits   = 16'h0;
    dp_in    = 4'h0;
    load     = 1'b0;
    hex_en   = 1'b0;
    lz_blank = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 4'b1111, 7'b0000000, 1'b0, 2'd0);

    // release reset with a load on the first edge; shadow still 0 for that edge's outputs
    digits = 16'h4321;
    load   = 1'b1;
    rst_n  = 1'b1;
    s      = 0;
    tick();
    load   = 1'b0;
    chk_out("first", 4'b1111, 7'b1111110, 1'b0, 2'd0);

    // one full scan period: 1 dead cycle then 3 lit cycles per slot
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] an_e;
      int d;
      d    = (k / RD) % NDIG;
      an_e = ((k % RD) == 0) ? 4'b1111 : ~(4'b0001 << d);
      tick();
      chk_out($sformatf("scan%0d", k), an_e, scan_tab[d], 1'b0, 2'(d));
    end

    // hex / decimal mode on digit 0 = A
    goto_state(0, 0);
    hex_en = 1'b1;
    do_load(16'h000A, 4'h0);
    tick();
    chk_out("hex_a", 4'b1110, 7'b1110111, 1'b0, 2'd0);
    hex_en = 1'b0;
    tick();
    chk_out("dec_a", 4'b1110, 7'b0000000, 1'b0, 2'd0);

    // leading-zero blanking
    lz_blank = 1'b1;
    do_load(16'h0070, 4'h0);
    check_slot("lz70_d1", 1, 7'b1110000, 1'b0);
    check_slot("lz70_d2", 2, 7'b0000000, 1'b0);
    check_slot("lz70_d3", 3, 7'b0000000, 1'b0);
    check_slot("lz70_d0", 0, 7'b1111110, 1'b0);
    do_load(16'h0000, 4'h0);
    check_slot("lz00_d3", 3, 7'b0000000, 1'b0);
    check_slot("lz00_d2", 2, 7'b0000000, 1'b0);
    check_slot("lz00_d1", 1, 7'b0000000, 1'b0);
    check_slot("lz00_d0", 0, 7'b1111110, 1'b0);
    lz_blank = 1'b0;
    check_slot("nolz_d3", 3, 7'b1111110, 1'b0);

    // tear-free: digits change without load leaves the display alone
    do_load(16'h4321, 4'h0);
    digits = 16'h9999;
    check_slot("tear_d0", 0, 7'b0110000, 1'b0);
    check_slot("tear_d1", 1, 7'b1101101, 1'b0);

    // load mid-slot during digit 0
    goto_state(0, 1);
    digits = 16'h0008;
    dp_in  = 4'b0001;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    chk_out("pre_load", 4'b1110, 7'b0110000, 1'b0, 2'd0);
    tick();
    chk_out("mid_load", 4'b1110, 7'b1111111, 1'b1, 2'd0);
    check_slot("dp_d1", 1, 7'b1111110, 1'b0);
    check_slot("dp_d0", 0, 7'b1111111, 1'b1);

    // reset in digit 2's slot
    goto_state(2, 1);
    tick();
    chk_out("pre_rst", 4'b1011, 7'b1111110, 1'b0, 2'd2);
    rst_n = 1'b0;
    tick();
    chk_out("mid_rst", 4'b1111, 7'b0000000, 1'b0, 2'd0);
    rst_n = 1'b1;
    s     = 0;
    tick();
    chk_out("restart0", 4'b1111, 7'b1111110, 1'b0, 2'd0);
    tick();
    chk_out("restart1", 4'b1110, 7'b1111110, 1'b0, 2'd0);
    check_slot("rst_d1", 1, 7'b1111110, 1'b0);
    do_load(16'h0005, 4'h0);
    check_slot("reload_d0", 0, 7'b1011011, 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
